// File: rtl/mem_access_unit_if.sv
// Request and memory-port bundle for mem_access_unit.
// The control side drives requests and read data; the unit drives the memory port.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fetch_req_i;
  logic [DATA_WIDTH-1:0] fetch_addr_i;
  logic                  ls_req_i;
  logic                  ls_we_i;
  logic [DATA_WIDTH-1:0] ls_addr_i;
  logic [DATA_WIDTH-1:0] ls_wdata_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [DATA_WIDTH-1:0] mdata_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  misalign_o;

  modport master (
    output fetch_req_i,
    output fetch_addr_i,
    output ls_req_i,
    output ls_we_i,
    output ls_addr_i,
    output ls_wdata_i,
    output mem_rdata_i,
    input  mem_addr_o,
    input  mem_wdata_o,
    input  mem_we_o,
    input  instr_o,
    input  mdata_o,
    input  busy_o,
    input  done_o,
    input  misalign_o
  );

  modport slave (
    input  fetch_req_i,
    input  fetch_addr_i,
    input  ls_req_i,
    input  ls_we_i,
    input  ls_addr_i,
    input  ls_wdata_i,
    input  mem_rdata_i,
    output mem_addr_o,
    output mem_wdata_o,
    output mem_we_o,
    output instr_o,
    output mdata_o,
    output busy_o,
    output done_o,
    output misalign_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// Unified memory initiator for the multicycle MIPS core.
// Fixed-latency reads into IR/MDR, single-cycle stores.
module mem_access_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE,
    DONE
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t                state;
  logic [2:0]            cnt;
  logic                  dst_ir;

  logic                  req_any;
  logic                  req_ls;
  logic                  req_store;
  logic                  req_ok;
  logic                  req_bad;
  logic [DATA_WIDTH-1:0] req_addr;

  // Load/store has priority over fetch.
  always_comb begin
    req_ls    = bus.ls_req_i;
    req_any   = bus.ls_req_i | bus.fetch_req_i;
    req_addr  = req_ls ? bus.ls_addr_i
                       : bus.fetch_addr_i;
    req_store = req_ls & bus.ls_we_i;
    req_ok    = req_any & (req_addr[1:0] == 2'b00);
    req_bad   = req_any & ~req_ok;
  end

  assign bus.busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= 3'd0;
      dst_ir          <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.mem_we_o    <= 1'b0;
      bus.instr_o     <= '0;
      bus.mdata_o     <= '0;
      bus.done_o      <= 1'b0;
      bus.misalign_o  <= 1'b0;
    end else begin
      bus.done_o     <= 1'b0;
      bus.misalign_o <= 1'b0;
      bus.mem_we_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            req_bad: begin
              bus.misalign_o <= 1'b1;
            end
            req_ok & req_store: begin
              bus.mem_addr_o  <= req_addr;
              bus.mem_wdata_o <= bus.ls_wdata_i;
              bus.mem_we_o    <= 1'b1;
              state           <= WRITE;
            end
            req_ok & ~req_store: begin
              bus.mem_addr_o <= req_addr;
              dst_ir         <= ~req_ls;
              cnt            <= LAT;
              state          <= READ_WAIT;
            end
            default: begin
            end
          endcase
        end
        READ_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            if (dst_ir)
              bus.instr_o <= bus.mem_rdata_i;
            else
              bus.mdata_o <= bus.mem_rdata_i;
            bus.done_o <= 1'b1;
            state      <= DONE;
          end
        end
        WRITE: begin
          bus.done_o <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (latency 1 and 3)
// share one stimulus and are checked against a schedule model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, ls_req, ls_we;
  logic [31:0] fetch_addr, ls_addr, ls_wdata, rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_WIDTH(32)) bus1 ();
  mem_access_unit_if #(.DATA_WIDTH(32)) bus3 ();

  assign bus1.fetch_req_i  = fetch_req;
  assign bus1.fetch_addr_i = fetch_addr;
  assign bus1.ls_req_i     = ls_req;
  assign bus1.ls_we_i      = ls_we;
  assign bus1.ls_addr_i    = ls_addr;
  assign bus1.ls_wdata_i   = ls_wdata;
  assign bus1.mem_rdata_i  = rdata;
  assign bus3.fetch_req_i  = fetch_req;
  assign bus3.fetch_addr_i = fetch_addr;
  assign bus3.ls_req_i     = ls_req;
  assign bus3.ls_we_i      = ls_we;
  assign bus3.ls_addr_i    = ls_addr;
  assign bus3.ls_wdata_i   = ls_wdata;
  assign bus3.mem_rdata_i  = rdata;

  mem_access_unit #(.DATA_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  mem_access_unit #(.DATA_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  logic [31:0] o_addr[2], o_wdata[2], o_instr[2], o_mdata[2];
  logic        o_we[2], o_busy[2], o_done[2], o_mis[2];

  assign o_addr[0]  = bus1.mem_addr_o;
  assign o_wdata[0] = bus1.mem_wdata_o;
  assign o_instr[0] = bus1.instr_o;
  assign o_mdata[0] = bus1.mdata_o;
  assign o_we[0]    = bus1.mem_we_o;
  assign o_busy[0]  = bus1.busy_o;
  assign o_done[0]  = bus1.done_o;
  assign o_mis[0]   = bus1.misalign_o;
  assign o_addr[1]  = bus3.mem_addr_o;
  assign o_wdata[1] = bus3.mem_wdata_o;
  assign o_instr[1] = bus3.instr_o;
  assign o_mdata[1] = bus3.mdata_o;
  assign o_we[1]    = bus3.mem_we_o;
  assign o_busy[1]  = bus3.busy_o;
  assign o_done[1]  = bus3.done_o;
  assign o_mis[1]   = bus3.misalign_o;

  // Model: an accepted access is a schedule of cycles 1..dur after accept.
  int          lat[2] = '{1, 3};
  bit          act[2];
  int          cyc[2];
  int          kind[2];
  logic [31:0] m_addr[2], m_wdata[2], m_instr[2], m_mdata[2];
  bit          m_mis[2];
  int          ndone[2];

  function automatic int dur_of(int i);
    return (kind[i] == 2) ? 2 : lat[i] + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        act[i] = 0; cyc[i] = 0; kind[i] = 0; m_mis[i] = 0;
        m_addr[i] = 0; m_wdata[i] = 0;
        m_instr[i] = 0; m_mdata[i] = 0;
      end else begin
        m_mis[i] = 0;
        if (act[i]) begin
          if (kind[i] != 2 && cyc[i] == lat[i]) begin
            if (kind[i] == 0) m_instr[i] = rdata;
            else m_mdata[i] = rdata;
          end
          if (cyc[i] == dur_of(i)) act[i] = 0;
          else cyc[i]++;
        end else if (ls_req || fetch_req) begin
          a = ls_req ? ls_addr : fetch_addr;
          if (a[1:0] != 2'b00) begin
            m_mis[i] = 1;
          end else begin
            act[i]    = 1;
            cyc[i]    = 1;
            kind[i]   = ls_req ? (ls_we ? 2 : 1) : 0;
            m_addr[i] = a;
            if (kind[i] == 2) m_wdata[i] = ls_wdata;
          end
        end
      end
    end
  endtask

  task automatic compare();
    string s;
    bit    e_done, e_we;
    for (int i = 0; i < 2; i++) begin
      s      = $sformatf("[L%0d]", lat[i]);
      e_done = act[i] && cyc[i] == dur_of(i);
      e_we   = act[i] && kind[i] == 2 && cyc[i] == 1;
      chk({"busy", s},  32'(o_busy[i]), 32'(act[i]));
      chk({"done", s},  32'(o_done[i]), 32'(e_done));
      chk({"we", s},    32'(o_we[i]),   32'(e_we));
      chk({"mis", s},   32'(o_mis[i]),  32'(m_mis[i]));
      chk({"addr", s},  o_addr[i],  m_addr[i]);
      chk({"wdata", s}, o_wdata[i], m_wdata[i]);
      chk({"instr", s}, o_instr[i], m_instr[i]);
      chk({"mdata", s}, o_mdata[i], m_mdata[i]);
      if (o_done[i]) ndone[i]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    fetch_req = 0; ls_req = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  int d0, d1;

  initial begin
    reset = 0; fetch_req = 0; ls_req = 0; ls_we = 0;
    fetch_addr = 0; ls_addr = 0; ls_wdata = 0; rdata = 0;
    step(); step();
    chk("rst addr", o_addr[0], 32'h0);
    chk("rst busy", 32'(o_busy[1]), 32'h0);
    reset = 1;
    idle(1);

    // Fetch, latency 1 and 3
    fetch_req = 1; fetch_addr = 32'h0040_0000; rdata = 32'h2008_0005;
    step(); fetch_req = 0;
    chk("f1 addr c1", o_addr[0], 32'h0040_0000);
    step();
    chk("f1 instr c2", o_instr[0], 32'h2008_0005);
    chk("f1 done c2", 32'(o_done[0]), 32'h1);
    step();
    chk("f1 busy c3", 32'(o_busy[0]), 32'h0);
    step();
    chk("f3 done c4", 32'(o_done[1]), 32'h1);
    idle(3);

    // Second fetch during READ_WAIT is dropped
    d0 = ndone[0]; d1 = ndone[1];
    fetch_req = 1; fetch_addr = 32'h0040_0004; rdata = 32'h8C09_0000;
    step();
    fetch_addr = 32'h0040_0008;
    step(); fetch_req = 0;
    step(); step();
    chk("f3b done c4", 32'(o_done[1]), 32'h1);
    chk("f3b instr", o_instr[1], 32'h8C09_0000);
    chk("f3b addr", o_addr[1], 32'h0040_0004);
    idle(3);
    chk("f3b ndone", 32'(ndone[1] - d1), 32'h1);
    chk("f1b ndone", 32'(ndone[0] - d0), 32'h1);

    // Store
    ls_req = 1; ls_we = 1; ls_addr = 32'h1001_0004;
    ls_wdata = 32'hDEAD_BEEF;
    step(); ls_req = 0; ls_we = 0;
    chk("st we c1", 32'(o_we[1]), 32'h1);
    chk("st wdata c1", o_wdata[0], 32'hDEAD_BEEF);
    chk("st addr c1", o_addr[0], 32'h1001_0004);
    step();
    chk("st done c2", 32'(o_done[0]), 32'h1);
    chk("st we c2", 32'(o_we[0]), 32'h0);
    chk("st instr", o_instr[0], 32'h8C09_0000);
    chk("st mdata", o_mdata[0], 32'h0);
    idle(3);

    // Simultaneous fetch and load: load wins
    d0 = ndone[0]; d1 = ndone[1];
    fetch_req = 1; fetch_addr = 32'h0040_000C;
    ls_req = 1; ls_addr = 32'h1001_0008; rdata = 32'h1234_5678;
    step(); fetch_req = 0; ls_req = 0;
    chk("ld addr c1", o_addr[1], 32'h1001_0008);
    step();
    chk("ld mdata c2", o_mdata[0], 32'h1234_5678);
    chk("ld instr c2", o_instr[0], 32'h8C09_0000);
    idle(4);
    chk("ld mdata L3", o_mdata[1], 32'h1234_5678);
    chk("ld ndone", 32'(ndone[0] - d0), 32'h1);
    chk("ld ndone L3", 32'(ndone[1] - d1), 32'h1);

    // Misaligned load
    d1 = ndone[1];
    ls_req = 1; ls_addr = 32'h1001_0002; rdata = 32'hCAFE_F00D;
    step(); ls_req = 0;
    chk("mis c1", 32'(o_mis[0]), 32'h1);
    chk("mis busy c1", 32'(o_busy[1]), 32'h0);
    step();
    chk("mis c2", 32'(o_mis[1]), 32'h0);
    chk("mis mdata", o_mdata[1], 32'h1234_5678);
    chk("mis addr", o_addr[1], 32'h1001_0008);

    // Misaligned fetch; misaligned store beating aligned fetch
    fetch_req = 1; fetch_addr = 32'h0040_0002;
    step(); fetch_req = 0;
    chk("misf c1", 32'(o_mis[0]), 32'h1);
    step();
    fetch_req = 1; fetch_addr = 32'h0040_0010;
    ls_req = 1; ls_we = 1; ls_addr = 32'h1001_0001;
    ls_wdata = 32'h5555_AAAA;
    step(); fetch_req = 0; ls_req = 0; ls_we = 0;
    chk("miss c1", 32'(o_mis[1]), 32'h1);
    chk("miss busy", 32'(o_busy[0]), 32'h0);
    idle(3);
    chk("mis ndone", 32'(ndone[1] - d1), 32'h0);

    // Reset during READ_WAIT
    fetch_req = 1; fetch_addr = 32'h0040_0014; rdata = 32'h1111_1111;
    step(); fetch_req = 0;
    step();
    reset = 0;
    step();
    chk("rst instr", o_instr[1], 32'h0);
    chk("rst mdata", o_mdata[1], 32'h0);
    chk("rst busy", 32'(o_busy[1]), 32'h0);
    reset = 1;
    d1 = ndone[1];
    idle(6);
    chk("rst ndone", 32'(ndone[1] - d1), 32'h0);

    // Fetch after reset recovers
    fetch_req = 1; fetch_addr = 32'h0040_0018; rdata = 32'h0000_000C;
    step(); fetch_req = 0;
    idle(5);
    chk("post instr L3", o_instr[1], 32'h0000_000C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
